instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives a 1-cycle-latency instruction ROM and presents instructions to decode.
// Ports: clk/reset, nop/branch_taken/branch_address in, imem_address/imem_data ROM, fetch outputs.
module instruction_fetch_unit #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'h0001,
  parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  nop,
  input  logic        branch_taken,
  input  logic [15:0] branch_address,
  output logic [15:0] imem_address,
  input  logic [19:0] imem_data,
  output logic [15:0] pc_fetch,
  output logic [19:0] instruction_fetch,
  output logic        fetch_valid,
  output logic [1:0]  flush_decode,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALTED
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] fetch_pc_q;
  logic [15:0] fetch_pc_d;
  logic [15:0] count_q;
  logic        stall;
  logic        take_br;
  logic        halt_go;
  logic        accept;

  // Priority is stall > branch > halt > step; decoded into
  // mutually exclusive terms so the one-hot case holds.
  assign stall   = |nop;
  assign take_br = !stall && branch_taken;
  assign halt_go = !stall && !branch_taken &&
                   (imem_data[19:15] == HALT_OPCODE);

  assign accept = fetch_valid && !stall &&
                  (flush_decode == 2'b00);

  assign instr_count = count_q;

  always_comb begin
    state_d           = state_q;
    fetch_pc_d        = fetch_pc_q;
    imem_address      = fetch_pc_q;
    pc_fetch          = 16'h0000;
    instruction_fetch = 20'h00000;
    fetch_valid       = 1'b0;
    flush_decode      = 2'b00;
    if (reset) begin
      // Reset overrides any stall or redirect in flight.
      state_d      = FILL;
      fetch_pc_d   = PC_RESET;
      imem_address = PC_RESET;
    end else begin
      unique case (state_q)
        FILL: begin
          state_d = RUN;
        end
        RUN: begin
          instruction_fetch = imem_data;
          pc_fetch          = fetch_pc_q;
          fetch_valid       = 1'b1;
          unique case (1'b1)
            stall: begin
              imem_address = fetch_pc_q;
            end
            take_br: begin
              imem_address = branch_address;
              fetch_pc_d   = branch_address;
              flush_decode = 2'b01;
            end
            halt_go: begin
              imem_address = fetch_pc_q;
              state_d      = HALTED;
            end
            default: begin
              imem_address = fetch_pc_q + PC_STEP;
              fetch_pc_d   = fetch_pc_q + PC_STEP;
            end
          endcase
        end
        HALTED: begin
          pc_fetch = fetch_pc_q;
          if (branch_taken) begin
            imem_address = branch_address;
            fetch_pc_d   = branch_address;
            state_d      = RUN;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      fetch_pc_q <= PC_RESET;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (accept) count_q <= count_q + 16'h0001;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous ROM model.
// Expectations are queued per step and popped when the cycle's outputs are sampled.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [19:0] instr;
    logic [1:0]  flush;
    logic [15:0] addr;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  nop;
  logic        branch_taken;
  logic [15:0] branch_address;
  logic [15:0] imem_address;
  logic [19:0] imem_data;
  logic [15:0] pc_fetch;
  logic [19:0] instruction_fetch;
  logic        fetch_valid;
  logic [1:0]  flush_decode;
  logic [15:0] instr_count;

  logic [15:0] imem_address_b;
  logic [19:0] imem_data_b;
  logic [15:0] pc_fetch_b;
  logic [19:0] instruction_fetch_b;
  logic        fetch_valid_b;
  logic [1:0]  flush_decode_b;
  logic [15:0] instr_count_b;

  int   checks;
  int   errors;
  exp_t sb[$];

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .nop               (nop),
    .branch_taken      (branch_taken),
    .branch_address    (branch_address),
    .imem_address      (imem_address),
    .imem_data         (imem_data),
    .pc_fetch          (pc_fetch),
    .instruction_fetch (instruction_fetch),
    .fetch_valid       (fetch_valid),
    .flush_decode      (flush_decode),
    .instr_count       (instr_count)
  );

  instruction_fetch_unit #(
    .PC_RESET (16'hFFFF)
  ) dut_wrap (
    .clk               (clk),
    .reset             (reset),
    .nop               (2'b00),
    .branch_taken      (1'b0),
    .branch_address    (16'h0000),
    .imem_address      (imem_address_b),
    .imem_data         (imem_data_b),
    .pc_fetch          (pc_fetch_b),
    .instruction_fetch (instruction_fetch_b),
    .fetch_valid       (fetch_valid_b),
    .flush_decode      (flush_decode_b),
    .instr_count       (instr_count_b)
  );

  function automatic logic [19:0] rom(input logic [15:0] a);
    if (a == 16'd6) return {5'b11111, 15'd6};
    return {5'b00001, a[14:0]};
  endfunction

  always @(posedge clk) begin
    imem_data   <= rom(imem_address);
    imem_data_b <= rom(imem_address_b);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic r,
                      input logic [1:0] n,
                      input logic b,
                      input logic [15:0] ba,
                      input logic v,
                      input logic [15:0] pc,
                      input logic [1:0] fl,
                      input logic [15:0] ad,
                      input logic [15:0] cn);
    exp_t e;
    @(negedge clk);
    reset          = r;
    nop            = n;
    branch_taken   = b;
    branch_address = ba;
    e.valid = v;
    e.pc    = pc;
    e.instr = v ? rom(pc) : 20'h00000;
    e.flush = fl;
    e.addr  = ad;
    e.cnt   = cn;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(fetch_valid), 32'(e.valid));
    chk({tag, ".pc"}, 32'(pc_fetch), 32'(e.pc));
    chk({tag, ".instr"}, 32'(instruction_fetch), 32'(e.instr));
    chk({tag, ".flush"}, 32'(flush_decode), 32'(e.flush));
    chk({tag, ".addr"}, 32'(imem_address), 32'(e.addr));
    chk({tag, ".cnt"}, 32'(instr_count), 32'(e.cnt));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    nop            = 2'b00;
    branch_taken   = 1'b0;
    branch_address = 16'h0000;
    repeat (2) @(posedge clk);

    // tag, rst, nop, br, ba, valid, pc, flush, addr, cnt
    step("rst", 1, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 16'h0000, 16'd0);
    chk("wrap.rst.addr", 32'(imem_address_b), 32'h0000FFFF);
    chk("wrap.rst.valid", 32'(fetch_valid_b), 32'h0);
    step("fill", 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 16'h0000, 16'd0);
    chk("wrap.fill.addr", 32'(imem_address_b), 32'h0000FFFF);
    step("pc0", 0, 2'b00, 0, 16'h0000, 1, 16'h0000, 2'b00, 16'h0001, 16'd0);
    chk("wrap.ffff.pc", 32'(pc_fetch_b), 32'h0000FFFF);
    chk("wrap.ffff.instr", 32'(instruction_fetch_b), 32'h0000FFFF);
    chk("wrap.ffff.addr", 32'(imem_address_b), 32'h00000000);
    step("pc1", 0, 2'b00, 0, 16'h0000, 1, 16'h0001, 2'b00, 16'h0002, 16'd1);
    chk("wrap.0000.pc", 32'(pc_fetch_b), 32'h00000000);
    chk("wrap.0000.valid", 32'(fetch_valid_b), 32'h1);
    step("stall_a", 0, 2'b01, 0, 16'h0000, 1, 16'h0002, 2'b00, 16'h0002, 16'd2);
    step("stall_b", 0, 2'b01, 0, 16'h0000, 1, 16'h0002, 2'b00, 16'h0002, 16'd2);
    step("pc2", 0, 2'b00, 0, 16'h0000, 1, 16'h0002, 2'b00, 16'h0003, 16'd2);
    step("pc3", 0, 2'b00, 0, 16'h0000, 1, 16'h0003, 2'b00, 16'h0004, 16'd3);
    step("br4", 0, 2'b00, 1, 16'h0010, 1, 16'h0004, 2'b01, 16'h0010, 16'd4);
    step("pc10", 0, 2'b00, 0, 16'h0000, 1, 16'h0010, 2'b00, 16'h0011, 16'd4);
    step("coll", 0, 2'b01, 1, 16'h0005, 1, 16'h0011, 2'b00, 16'h0011, 16'd5);
    step("br11", 0, 2'b00, 1, 16'h0005, 1, 16'h0011, 2'b01, 16'h0005, 16'd5);
    step("pc5", 0, 2'b00, 0, 16'h0000, 1, 16'h0005, 2'b00, 16'h0006, 16'd5);
    step("halt", 0, 2'b00, 0, 16'h0000, 1, 16'h0006, 2'b00, 16'h0006, 16'd6);
    step("hlt_a", 0, 2'b00, 0, 16'h0000, 0, 16'h0006, 2'b00, 16'h0006, 16'd7);
    step("hlt_b", 0, 2'b00, 0, 16'h0000, 0, 16'h0006, 2'b00, 16'h0006, 16'd7);
    step("hlt_br", 0, 2'b00, 1, 16'h0000, 0, 16'h0006, 2'b00, 16'h0000, 16'd7);
    step("res0", 0, 2'b00, 0, 16'h0000, 1, 16'h0000, 2'b00, 16'h0001, 16'd7);
    step("res1", 0, 2'b00, 0, 16'h0000, 1, 16'h0001, 2'b00, 16'h0002, 16'd8);
    step("mrst", 1, 2'b01, 1, 16'h0030, 0, 16'h0000, 2'b00, 16'h0000, 16'd9);
    step("refill", 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 16'h0000, 16'd0);
    step("rbr0", 0, 2'b00, 1, 16'h0006, 1, 16'h0000, 2'b01, 16'h0006, 16'd0);
    step("wrongp", 0, 2'b00, 1, 16'h0020, 1, 16'h0006, 2'b01, 16'h0020, 16'd0);
    step("pc20", 0, 2'b00, 0, 16'h0000, 1, 16'h0020, 2'b00, 16'h0021, 16'd0);
    step("pc21", 0, 2'b00, 0, 16'h0000, 1, 16'h0021, 2'b00, 16'h0022, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
